// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and data memory.
interface mem_access_if;
    logic        MemReq;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;

    modport master (
        output MemReq, MemWE, MemAddr, MemWData,
        input  MemAck, MemRData
    );

    modport slave (
        input  MemReq, MemWE, MemAddr, MemWData,
        output MemAck, MemRData
    );
endinterface

// File: rtl/mem_access.sv
// MIPS memory-access stage: single-word req/ack data-memory access, stalls upstream while busy.
// Optional abort of unacknowledged accesses with a sticky BusError: define MEM_TIMEOUT_EN.
module mem_access
`ifdef MEM_TIMEOUT_EN
    #(parameter int unsigned TIMEOUT = 16)
`endif
    (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] ALUOut,
    input  logic [31:0] RtDataIn,
    input  logic [4:0]  RAddrIn,
    input  logic        RegWriteIn,
    input  logic        MemReadIn,
    input  logic        MemtoRegIn,
    input  logic        MemWriteIn,
    mem_access_if.master bus,
    output logic        Stall,
    output logic [31:0] WBData,
    output logic [4:0]  RAddrOut,
`ifdef MEM_TIMEOUT_EN
    output logic        RegWriteOut,
    output logic        BusError
`else
    output logic        RegWriteOut
`endif
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state;
    logic [4:0] hold_raddr;
    logic       hold_regwrite;
    logic       hold_memtoreg;
    logic       expired;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;

    assign expired = (state == ACCESS) && !bus.MemAck && (wait_cnt == LAST);
`else
    assign expired = 1'b0;
`endif

    assign Stall = (state == ACCESS) && !bus.MemAck && !expired;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            bus.MemReq    <= 1'b0;
            bus.MemWE     <= 1'b0;
            bus.MemAddr   <= '0;
            bus.MemWData  <= '0;
            WBData        <= '0;
            RAddrOut      <= '0;
            RegWriteOut   <= 1'b0;
            hold_raddr    <= '0;
            hold_regwrite <= 1'b0;
            hold_memtoreg <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt      <= '0;
            BusError      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (MemReadIn || MemWriteIn) begin
                        // write wins when both are set
                        bus.MemAddr   <= ALUOut;
                        bus.MemWData  <= RtDataIn;
                        bus.MemWE     <= MemWriteIn;
                        bus.MemReq    <= 1'b1;
                        hold_raddr    <= RAddrIn;
                        hold_regwrite <= RegWriteIn;
                        hold_memtoreg <= MemtoRegIn;
                        RegWriteOut   <= 1'b0;
                        state         <= ACCESS;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end else begin
                        WBData      <= ALUOut;
                        RAddrOut    <= RAddrIn;
                        RegWriteOut <= RegWriteIn;
                    end
                end
                ACCESS: begin
                    RegWriteOut <= 1'b0;
                    if (bus.MemAck) begin
                        bus.MemReq  <= 1'b0;
                        state       <= IDLE;
                        WBData      <= hold_memtoreg ? bus.MemRData : bus.MemAddr;
                        RAddrOut    <= hold_raddr;
                        RegWriteOut <= hold_regwrite;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (expired) begin
                        bus.MemReq <= 1'b0;
                        state      <= IDLE;
                        BusError   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a transaction-level model.
module tb_mem_access;

`ifdef MEM_TIMEOUT_EN
    localparam bit TE = 1'b1;
    localparam int TO = 4;
`else
    localparam bit TE = 1'b0;
    localparam int TO = 0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] ALUOut, RtDataIn;
    logic [4:0]  RAddrIn;
    logic        RegWriteIn, MemReadIn, MemtoRegIn, MemWriteIn;
    logic        Stall;
    logic [31:0] WBData;
    logic [4:0]  RAddrOut;
    logic        RegWriteOut;
`ifdef MEM_TIMEOUT_EN
    logic        BusError;
`endif

    mem_access_if bus();

`ifdef MEM_TIMEOUT_EN
    mem_access #(.TIMEOUT(TO)) dut (
`else
    mem_access dut (
`endif
        .Clock(Clock), .Reset(Reset),
        .ALUOut(ALUOut), .RtDataIn(RtDataIn), .RAddrIn(RAddrIn),
        .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn),
        .MemtoRegIn(MemtoRegIn), .MemWriteIn(MemWriteIn),
        .bus(bus.master),
        .Stall(Stall), .WBData(WBData), .RAddrOut(RAddrOut),
`ifdef MEM_TIMEOUT_EN
        .RegWriteOut(RegWriteOut), .BusError(BusError)
`else
        .RegWriteOut(RegWriteOut)
`endif
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        int          waited;
    } txn_t;

    txn_t        cur;
    bit          busy = 1'b0;
    bit          armed = 1'b0;
    bit          e_zero = 1'b0;
    logic [31:0] e_wb;
    logic [4:0]  e_rd;
    logic        e_rw, e_req, e_err;

    always @(negedge Clock) begin
        if (armed) begin
            check("MemReq", 32'(bus.MemReq), 32'(e_req));
            check("Stall", 32'(Stall),
                  32'(busy && !bus.MemAck && !(TE && cur.waited == TO - 1)));
            check("WBData", WBData, e_wb);
            check("RAddrOut", 32'(RAddrOut), 32'(e_rd));
            check("RegWriteOut", 32'(RegWriteOut), 32'(e_rw));
            if (e_req || e_zero) begin
                check("MemWE", 32'(bus.MemWE), 32'(cur.we));
                check("MemAddr", bus.MemAddr, cur.addr);
                check("MemWData", bus.MemWData, cur.wdata);
            end
`ifdef MEM_TIMEOUT_EN
            check("BusError", 32'(BusError), 32'(e_err));
`endif
        end
        if (Reset) begin
            cur    = '{32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0};
            busy   = 1'b0;
            e_wb   = '0;
            e_rd   = '0;
            e_rw   = 1'b0;
            e_req  = 1'b0;
            e_err  = 1'b0;
            e_zero = 1'b1;
            armed  = 1'b1;
        end else if (!busy) begin
            if (MemReadIn || MemWriteIn) begin
                cur    = '{ALUOut, RtDataIn, MemWriteIn, RAddrIn,
                           RegWriteIn, MemtoRegIn, 0};
                busy   = 1'b1;
                e_req  = 1'b1;
                e_rw   = 1'b0;
                e_zero = 1'b0;
            end else begin
                e_wb = ALUOut;
                e_rd = RAddrIn;
                e_rw = RegWriteIn;
            end
        end else begin
            e_rw = 1'b0;
            if (bus.MemAck) begin
                e_wb  = cur.m2r ? bus.MemRData : cur.addr;
                e_rd  = cur.rd;
                e_rw  = cur.rw;
                busy  = 1'b0;
                e_req = 1'b0;
            end else if (TE && cur.waited == TO - 1) begin
                busy  = 1'b0;
                e_req = 1'b0;
                e_err = 1'b1;
            end else begin
                cur.waited++;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic op(logic [31:0] alu, logic [31:0] rt, logic [4:0] rd,
                      logic rw, logic rden, logic m2r, logic wr);
        ALUOut     = alu;
        RtDataIn   = rt;
        RAddrIn    = rd;
        RegWriteIn = rw;
        MemReadIn  = rden;
        MemtoRegIn = m2r;
        MemWriteIn = wr;
    endtask

    task automatic idle();
        op(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        bus.MemAck   = 1'b0;
        bus.MemRData = '0;
        repeat (2) tick();
        Reset = 1'b0;
        check("rst MemReq", 32'(bus.MemReq), 32'd0);
        check("rst WBData", WBData, 32'd0);
        check("rst RegWriteOut", 32'(RegWriteOut), 32'd0);
        check("rst RAddrOut", 32'(RAddrOut), 32'd0);
        check("rst Stall", 32'(Stall), 32'd0);

        // ALU op
        op(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("alu WBData", WBData, 32'h0000_1234);
        check("alu RAddrOut", 32'(RAddrOut), 32'd5);
        check("alu RegWriteOut", 32'(RegWriteOut), 32'd1);
        check("alu MemReq", 32'(bus.MemReq), 32'd0);

        // Load with immediate ack
        op(32'h100, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("ld MemReq", 32'(bus.MemReq), 32'd1);
        check("ld MemWE", 32'(bus.MemWE), 32'd0);
        check("ld MemAddr", bus.MemAddr, 32'h100);
        check("ld bubble", 32'(RegWriteOut), 32'd0);
        idle();
        bus.MemAck   = 1'b1;
        bus.MemRData = 32'hDEAD_BEEF;
        #1;
        check("ld Stall", 32'(Stall), 32'd0);
        tick();
        bus.MemAck = 1'b0;
        check("ld WBData", WBData, 32'hDEAD_BEEF);
        check("ld RAddrOut", 32'(RAddrOut), 32'd7);
        check("ld RegWriteOut", 32'(RegWriteOut), 32'd1);
        check("ld MemReq drop", 32'(bus.MemReq), 32'd0);

        // Store with 3 wait cycles
        op(32'h200, 32'hCAFE_0001, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        check("st MemWE", 32'(bus.MemWE), 32'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st Stall", 32'(Stall), 32'd1);
            check("st MemAddr", bus.MemAddr, 32'h200);
            check("st MemWData", bus.MemWData, 32'hCAFE_0001);
            tick();
            check("st bubble", 32'(RegWriteOut), 32'd0);
        end
        bus.MemAck = 1'b1;
        #1;
        check("st ack Stall", 32'(Stall), 32'd0);
        check("st MemAddr4", bus.MemAddr, 32'h200);
        tick();
        bus.MemAck = 1'b0;
        check("st done MemReq", 32'(bus.MemReq), 32'd0);
        check("st RegWriteOut", 32'(RegWriteOut), 32'd0);

        // Reset during the 2nd wait cycle, then a late ack
        op(32'h300, 32'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rw MemReq", 32'(bus.MemReq), 32'd0);
        check("rw WBData", WBData, 32'd0);
        check("rw RAddrOut", 32'(RAddrOut), 32'd0);
        bus.MemAck   = 1'b1;
        bus.MemRData = 32'h1111_2222;
        tick();
        bus.MemAck = 1'b0;
        check("late ack MemReq", 32'(bus.MemReq), 32'd0);
        check("late ack RegWriteOut", 32'(RegWriteOut), 32'd0);
        check("late ack WBData", WBData, 32'd0);

`ifdef MEM_TIMEOUT_EN
        begin
            int cnt;
            op(32'h400, 32'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            idle();
            cnt = 0;
            for (int i = 0; i < 12 && bus.MemReq; i++) begin
                cnt++;
                tick();
            end
            check("to MemReq width", 32'(cnt), 32'd4);
            check("to BusError", 32'(BusError), 32'd1);
            check("to RegWriteOut", 32'(RegWriteOut), 32'd0);
            op(32'h55, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            repeat (3) tick();
            check("to sticky", 32'(BusError), 32'd1);
            Reset = 1'b1;
            tick();
            Reset = 1'b0;
            check("to cleared", 32'(BusError), 32'd0);
        end
`endif

        // Randomized traffic
        repeat (800) begin
            int kind;
            Reset = ($urandom_range(0, 99) < 2);
            kind  = $urandom_range(0, 7);
            op($urandom, $urandom, 5'($urandom), 1'($urandom),
               (kind == 4 || kind == 5 || kind == 7),
               1'($urandom),
               (kind == 6 || kind == 7));
            bus.MemAck   = ($urandom_range(0, 2) == 0);
            bus.MemRData = $urandom;
            tick();
        end
        Reset = 1'b0;
        idle();
        bus.MemAck = 1'b1;
        repeat (3) tick();
        bus.MemAck = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
